// File: rtl/stream_demux_pkg.sv
// Shared constants and helpers for the stream_demux block and its per-port FIFOs.
package stream_demux_pkg;

  localparam int QDEPTH = 2;
  localparam int CNT_W  = 16;
  localparam int PTR_W  = 1;

  // Occupancy of a 2-entry queue: 0, 1 or 2.
  typedef logic [1:0] qcnt_t;

  typedef enum logic [1:0] {
    QOP_IDLE = 2'b00,
    QOP_POP  = 2'b01,
    QOP_PUSH = 2'b10,
    QOP_BOTH = 2'b11
  } qop_e;

  function automatic qcnt_t qcnt_next(input qcnt_t cnt, input logic push, input logic pop);
    qcnt_t res;
    res = cnt;
    case (qop_e'({push, pop}))
      QOP_PUSH: res = cnt + 2'd1;
      QOP_POP:  res = cnt - 2'd1;
      default:  res = cnt;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/demux_fifo2.sv
// Two-entry FIFO with 1-bit wrapping pointers; push/pop are self-guarded against
// overflow/underflow and the head reads as zero while empty.
module demux_fifo2
  import stream_demux_pkg::*;
#(
  parameter int bit_size = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic                pop,
  input  logic [bit_size-1:0] wdata,
  output logic [bit_size-1:0] rdata,
  output logic                full,
  output logic                empty
);

  logic [bit_size-1:0] mem [QDEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  qcnt_t               count;
  logic                push_ok;
  logic                pop_ok;

  assign full    = (count == qcnt_t'(QDEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= qcnt_next(count, push_ok, pop_ok);
    end
  end

  // Storage is left unreset: an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/stream_demux.sv
// Steers one input stream into two independently drained 2-entry queues.
// Optional pop counters cnt0/cnt1 are built when STREAM_DEMUX_CNT_EN is defined.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int bit_size = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [bit_size-1:0] in_data,
  input  logic                in_sel,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [bit_size-1:0] out0_data,
  output logic                out0_valid,
  input  logic                out0_ready,
  output logic [bit_size-1:0] out1_data,
  output logic                out1_valid,
  input  logic                out1_ready
`ifdef STREAM_DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0]    cnt0,
  output logic [CNT_W-1:0]    cnt1
`endif
);

  logic full0, full1;
  logic empty0, empty1;
  logic accept;
  logic push0, push1;
  logic pop0, pop1;

  // Readiness looks only at the selected queue; a pop this cycle does not free space early.
  assign in_ready = in_sel ? ~full1 : ~full0;
  assign accept   = in_valid & in_ready;
  assign push0    = accept & ~in_sel;
  assign push1    = accept &  in_sel;

  assign out0_valid = ~empty0;
  assign out1_valid = ~empty1;
  assign pop0       = out0_valid & out0_ready;
  assign pop1       = out1_valid & out1_ready;

  demux_fifo2 #(.bit_size(bit_size)) u_fifo0 (
    .clk   (clk),
    .rst   (rst),
    .push  (push0),
    .pop   (pop0),
    .wdata (in_data),
    .rdata (out0_data),
    .full  (full0),
    .empty (empty0)
  );

  demux_fifo2 #(.bit_size(bit_size)) u_fifo1 (
    .clk   (clk),
    .rst   (rst),
    .push  (push1),
    .pop   (pop1),
    .wdata (in_data),
    .rdata (out1_data),
    .full  (full1),
    .empty (empty1)
  );

`ifdef STREAM_DEMUX_CNT_EN
  // Free-running pop counters; natural modulo-2^CNT_W wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (pop0) cnt0 <= cnt0 + 1'b1;
      if (pop1) cnt1 <= cnt1 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: queue-based reference model plus literal spot checks.
module tb_stream_demux;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out0_data;
  logic        out0_valid;
  logic        out0_ready;
  logic [15:0] out1_data;
  logic        out1_valid;
  logic        out1_ready;
`ifdef STREAM_DEMUX_CNT_EN
  logic [15:0] cnt0;
  logic [15:0] cnt1;
`endif

  int nvec = 0;
  int nerr = 0;

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] mcnt0 = 16'h0;
  logic [15:0] mcnt1 = 16'h0;
  bit          started = 1'b0;

  always #5 clk = ~clk;

  stream_demux #(.bit_size(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready)
`ifdef STREAM_DEMUX_CNT_EN
    ,
    .cnt0       (cnt0),
    .cnt1       (cnt1)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: two bounded queues updated by the accept/pop rules at each edge.
  initial begin
    bit acc, p0, p1;
    forever begin
      @(posedge clk);
      if (rst) begin
        q0.delete();
        q1.delete();
        mcnt0 = 16'h0;
        mcnt1 = 16'h0;
      end else begin
        acc = in_valid && ((in_sel ? q1.size() : q0.size()) < 2);
        p0  = out0_ready && (q0.size() > 0);
        p1  = out1_ready && (q1.size() > 0);
        if (p0) begin void'(q0.pop_front()); mcnt0 = mcnt0 + 16'h1; end
        if (p1) begin void'(q1.pop_front()); mcnt1 = mcnt1 + 16'h1; end
        if (acc) begin
          if (in_sel) q1.push_back(in_data);
          else        q0.push_back(in_data);
        end
      end
      started = 1'b1;
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("in_ready",   in_ready,   ((in_sel ? q1.size() : q0.size()) < 2) ? 1 : 0);
        chk("out0_valid", out0_valid, (q0.size() > 0) ? 1 : 0);
        chk("out0_data",  out0_data,  (q0.size() > 0) ? q0[0] : 16'h0);
        chk("out1_valid", out1_valid, (q1.size() > 0) ? 1 : 0);
        chk("out1_data",  out1_data,  (q1.size() > 0) ? q1[0] : 16'h0);
`ifdef STREAM_DEMUX_CNT_EN
        chk("cnt0", cnt0, mcnt0);
        chk("cnt1", cnt1, mcnt1);
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [15:0] d,
                       input logic r0, input logic r1);
    in_valid   = v;
    in_sel     = s;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b0;

    at_neg();
    chk("rst_out0_valid", out0_valid, 0);
    chk("rst_out1_valid", out1_valid, 0);
    chk("rst_out0_data",  out0_data,  0);
    chk("rst_out1_data",  out1_data,  0);
    chk("rst_in_ready",   in_ready,   1);

    // Single word to port 0
    drive(1'b1, 1'b0, 16'h00A5, 1'b1, 1'b0);
    step();
    drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    at_neg();
    chk("lat_out0_valid", out0_valid, 1);
    chk("lat_out0_data",  out0_data,  16'h00A5);
    chk("lat_out1_valid", out1_valid, 0);
    step();
    at_neg();
    chk("drain_out0_valid", out0_valid, 0);
    chk("drain_out0_data",  out0_data,  0);

    // Fill port 1, third offer stalls, then drain in order
    drive(1'b1, 1'b1, 16'h0001, 1'b1, 1'b0);
    step();
    drive(1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
    step();
    drive(1'b1, 1'b1, 16'h0003, 1'b1, 1'b0);
    at_neg();
    chk("full1_in_ready", in_ready, 0);
    chk("full1_head",     out1_data, 16'h0001);
    step();
    drive(1'b1, 1'b1, 16'h0003, 1'b1, 1'b1);
    at_neg();
    chk("nobypass_in_ready", in_ready, 0);
    chk("order_w1", out1_data, 16'h0001);
    step();
    at_neg();
    chk("order_w2", out1_data, 16'h0002);
    chk("space_in_ready", in_ready, 1);
    step();
    drive(1'b0, 1'b1, 16'h0, 1'b1, 1'b1);
    at_neg();
    chk("order_w3", out1_data, 16'h0003);
    step();
    at_neg();
    chk("empty1_valid", out1_valid, 0);

    // Simultaneous push and pop at count 1
    drive(1'b1, 1'b0, 16'h1111, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b0, 16'h2222, 1'b1, 1'b0);
    at_neg();
    chk("pp_in_ready", in_ready, 1);
    chk("pp_head_old", out0_data, 16'h1111);
    step();
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    at_neg();
    chk("pp_head_new", out0_data, 16'h2222);
    chk("pp_valid",    out0_valid, 1);

    // Full port 0 does not block port 1
    drive(1'b1, 1'b0, 16'h3333, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b0);
    at_neg();
    chk("indep_in_ready", in_ready, 1);
    step();
    drive(1'b1, 1'b1, 16'h4444, 1'b0, 1'b0);
    at_neg();
    chk("indep_out1_data",  out1_data,  16'hBEEF);
    chk("indep_out1_valid", out1_valid, 1);
    step();
    drive(1'b1, 1'b0, 16'h5555, 1'b0, 1'b0);
    at_neg();
    chk("both_full_in_ready", in_ready, 0);

    // Reset with both queues full; accept and pops in that cycle are discarded
    rst = 1'b1;
    drive(1'b1, 1'b0, 16'h6666, 1'b1, 1'b1);
    step();
    rst = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    at_neg();
    chk("mrst_out0_valid", out0_valid, 0);
    chk("mrst_out1_valid", out1_valid, 0);
    chk("mrst_out0_data",  out0_data,  0);
    chk("mrst_out1_data",  out1_data,  0);
    chk("mrst_in_ready",   in_ready,   1);

    // Mixed traffic pattern checked by the model
    for (int i = 0; i < 48; i++) begin
      drive((i % 3) != 2, ((i >> 1) % 2) == 1, 16'h5000 + 16'(i),
            (i % 4) != 0, (i % 5) < 2);
      step();
    end
    drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    repeat (3) step();

`ifdef STREAM_DEMUX_CNT_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b1, 1'b0, 16'h7777, 1'b1, 1'b0);
    repeat (65538) step();
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    at_neg();
    chk("cnt0_wrap", cnt0, 16'h0001);
    chk("cnt1_idle", cnt1, 16'h0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 Parameter: bit_size, default 16, data width of every data port.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_data  input  bit_size  word to be steered.
REQ-005 in_sel  input  1  destination: 0 -> port 0, 1 -> port 1.
REQ-006 in_valid  input  1  in_data/in_sel valid this cycle.
REQ-007 in_ready  output  1  block accepts the offered word this cycle.
REQ-008 out0_data / out1_data  output  bit_size  head word of each output queue.
REQ-009 out0_valid / out1_valid  output  1  corresponding queue non-empty.
REQ-010 out0_ready / out1_ready  input  1  consumer takes the head word this cycle.

Function
REQ-011 Each output SHALL own a 2-entry FIFO queue; count per queue 0..2.
REQ-012 in_ready SHALL be combinational: 1 iff count of queue[in_sel] < 2; no bypass from pop.
REQ-013 Accept = in_valid & in_ready; on accept, in_data SHALL be written to the tail of queue[in_sel] at that edge.
REQ-014 Latency: an accepted word SHALL appear on outN_data with outN_valid=1 the cycle after acceptance when its queue was empty; there is no combinational in-to-out path.
REQ-015 Pop = outN_valid & outN_ready; the head SHALL be removed at that edge and the next entry shown the following cycle.
REQ-016 Push and pop on the same queue in one cycle (count 1) SHALL leave count at 1, with the new word at the head next cycle.
REQ-017 Push to one queue and pop from the other in one cycle SHALL both take effect independently.
REQ-018 outN_ready while outN_valid=0 SHALL be ignored; count never underflows.
REQ-019 Words SHALL leave each queue in acceptance order; no word is dropped or duplicated.
REQ-020 A full queue SHALL NOT block acceptance for the other queue (in_ready depends only on the selected queue).
REQ-021 outN_data SHALL be 0 whenever outN_valid=0.
REQ-022 Queue pointers SHALL be 1 bit and wrap 1 -> 0.

Reset
REQ-023 While rst=1 at a clock edge, all counts and pointers SHALL clear to 0; out0_valid = out1_valid = 0, out0_data = out1_data = 0 the next cycle.
REQ-024 Reset mid-transfer SHALL discard all queued words; any accept or pop in the reset cycle SHALL be ignored.
REQ-025 in_ready SHALL be 1 in the first cycle after reset.

Configuration
REQ-026 Macro STREAM_DEMUX_CNT_EN: when defined, add outputs cnt0, cnt1 (16 bits each) counting pops on port 0/1, cleared by rst, wrapping 0xFFFF -> 0x0000.
REQ-027 When STREAM_DEMUX_CNT_EN is undefined, cnt0/cnt1 ports and their logic SHALL be absent; all other behaviour unchanged.

Structure
REQ-028 Package stream_demux_pkg SHALL hold constants QDEPTH = 2 and CNT_W = 16.
REQ-029 Sub-module demux_fifo2 (2-entry FIFO: push, pop, data, full, empty) SHALL be instantiated once per output.

Verification
REQ-030 Reset, then in_sel=0, in_data=16'h00A5, in_valid=1 for one cycle, out0_ready=1 -> out0_valid=1, out0_data=16'h00A5 next cycle; out1_valid stays 0.
REQ-031 out1_ready=0, push 16'h0001, 16'h0002, 16'h0003 to port 1 -> first two accepted; in_ready=0 on the third; raise out1_ready -> 16'h0001, 16'h0002, 16'h0003 in order.
REQ-032 Port 0 full with out0_ready=0, offer sel=1 word 16'hBEEF -> in_ready=1, accepted; appears on out1_data next cycle.
REQ-033 Queue 0 holds 16'h1111, out0_ready=1, simultaneous push 16'h2222 sel=0 -> count stays 1, out0_data=16'h2222 next cycle.
REQ-034 Both queues full, assert rst for one cycle -> out0_valid = out1_valid = 0, data outputs 0, in_ready=1 next cycle.
REQ-035 With STREAM_DEMUX_CNT_EN, 65537 pops on port 0 -> cnt0=1; without the macro, build compiles with no cnt ports.
